// File: rtl/clk_en_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_en_seq : PLL-lock qualified release sequencer with per-channel clock enables
// Revision   : 1.0
// ----------------------------------------------------------------------------
module clk_en_seq #(
  parameter int                        NUM_CH      = 3,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DIVS        = {8'd40, 8'd10, 8'd4},
  parameter int                        LOCK_CYCLES = 1024,
  parameter int                        SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lock,
  input  logic              align,
  output logic              ready,
  output logic              rst_out_n,
  output logic [NUM_CH-1:0] en,
  output logic [7:0]        loss_cnt
);

  localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_CYCLES - 2);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       settle_cnt;
  logic [CNT_W-1:0]       settle_nxt;

  logic                   run_now;
  logic                   run_nxt;
  logic                   restart;
  logic                   lost;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // The WAIT_LOCK->SETTLE edge already counts as the first locked cycle, so
  // SETTLE leaves one count early and ready lands SYNC_STAGES+LOCK_CYCLES after lock.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    if (!lock_s) begin
      state_nxt  = WAIT_LOCK;
      settle_nxt = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_nxt  = SETTLE;
          settle_nxt = '0;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt  = RUN;
            settle_nxt = '0;
          end else begin
            settle_nxt = settle_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt  = WAIT_LOCK;
          settle_nxt = '0;
        end
      endcase
    end
  end

  assign run_now = (state == RUN);
  assign run_nxt = (state_nxt == RUN);
  assign restart = align & run_now;
  assign lost    = run_now & (state_nxt == WAIT_LOCK);

  // ready is taken from the next state so it rises on the same edge as RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready    <= 1'b0;
      loss_cnt <= 8'd0;
    end else begin
      ready <= run_nxt;
      if (lost && (loss_cnt != 8'hFF)) begin
        loss_cnt <= loss_cnt + 8'd1;
      end
    end
  end

  assign rst_out_n = ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [DIV_W-1:0] RAW    = DIVS[i*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] RELOAD = (RAW == '0) ? '0 : (RAW - DIV_W'(1));

    logic [DIV_W-1:0] cnt;
    logic             en_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt  <= RELOAD;
        en_q <= 1'b0;
      end else begin
        if (!run_now || restart || (cnt == '0)) begin
          cnt <= RELOAD;
        end else begin
          cnt <= cnt - DIV_W'(1);
        end
        en_q <= run_nxt && !restart && (cnt == '0);
      end
    end

    assign en[i] = en_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_en_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_clk_en_seq : directed + random checks of clk_en_seq against an edge-count model
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_clk_en_seq;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int SYNC_STAGES = 2;
  localparam logic [NUM_CH*DIV_W-1:0] DIVS = {8'd4, 8'd3, 8'd1};

  logic              clk = 1'b0;
  logic              reset_n;
  logic              lock;
  logic              align;
  logic              ready;
  logic              rst_out_n;
  logic [NUM_CH-1:0] en;
  logic [7:0]        loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int   dv [NUM_CH];
  bit   ls [SYNC_STAGES];
  int   run_len;
  int   elapsed;
  bit   from_align;
  bit   m_ready;
  logic [NUM_CH-1:0] m_en;
  int   m_loss;

  clk_en_seq #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DIVS        (DIVS),
    .LOCK_CYCLES (LOCK_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .lock      (lock),
    .align     (align),
    .ready     (ready),
    .rst_out_n (rst_out_n),
    .en        (en),
    .loss_cnt  (loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SYNC_STAGES; s++) ls[s] = 1'b0;
    run_len    = 0;
    elapsed    = 0;
    from_align = 1'b0;
    m_ready    = 1'b0;
    m_en       = '0;
    m_loss     = 0;
  endtask

  // ready = lock has been seen (after the synchroniser delay) on LOCK_CYCLES
  // consecutive edges; enables fire every D edges counted from ready rise or align.
  task automatic model_edge();
    bit ls_b;
    bit ready_prev;
    ls_b = ls[SYNC_STAGES-1];
    for (int s = SYNC_STAGES - 1; s > 0; s--) ls[s] = ls[s-1];
    ls[0]      = lock;
    ready_prev = m_ready;
    run_len    = ls_b ? run_len + 1 : 0;
    if (run_len > LOCK_CYCLES) run_len = LOCK_CYCLES;
    m_ready = (run_len >= LOCK_CYCLES);
    if (m_ready && !ready_prev) begin
      elapsed    = 0;
      from_align = 1'b0;
    end else if (ready_prev && align) begin
      elapsed    = 0;
      from_align = 1'b1;
    end else if (elapsed < 1000000) begin
      elapsed++;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      m_en[i] = m_ready && ((elapsed % dv[i]) == 0) &&
                ((elapsed > 0) || (!from_align && dv[i] == 1));
    end
    if (ready_prev && !m_ready && m_loss < 255) m_loss++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    chk("ready",     8'(ready),     8'(m_ready));
    chk("rst_out_n", 8'(rst_out_n), 8'(m_ready));
    chk("en",        8'(en),        8'(m_en));
    chk("loss_cnt",  loss_cnt,      8'(m_loss));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},     8'(ready),     8'd0);
    chk({tag, "_rst_out_n"}, 8'(rst_out_n), 8'd0);
    chk({tag, "_en"},        8'(en),        8'd0);
    chk({tag, "_loss"},      loss_cnt,      8'd0);
  endtask

  task automatic wait_ready(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (ready === 1'b1) break;
      tick();
    end
    chk("wait_ready", 8'(ready), 8'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dv[0] = 1;
    dv[1] = 3;
    dv[2] = 4;
    model_reset();
    lock    = 1'b0;
    align   = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("por");
    tick();
    tick();
    reset_n = 1'b1;

    // Glitch during settle at count 10: full restart, no loss counted.
    tick();
    lock = 1'b1;
    repeat (13) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    repeat (17) tick();
    chk("glitch_hold", 8'(ready), 8'd0);
    tick();
    chk("glitch_rise", 8'(ready), 8'd1);
    chk("glitch_loss", loss_cnt, 8'd0);

    // Async reset between edges while running.
    repeat (3) tick();
    #3 reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    lock = 1'b0;
    tick();
    reset_n = 1'b1;

    // Release timing and enable phases, with align on an en[2] edge.
    tick();
    lock = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      align = (e == 26);
      tick();
      if (e == 17) chk("pre_ready", 8'(ready), 8'd0);
      if (e == 18) begin
        chk("rise_ready", 8'(ready),     8'd1);
        chk("rise_rstn",  8'(rst_out_n), 8'd1);
        chk("rise_en",    8'(en),        8'b001);
      end
      if (e == 21) chk("en1_first", 8'(en), 8'b011);
      if (e == 22) chk("en2_first", 8'(en), 8'b101);
      if (e == 26) chk("align_kill", 8'(en), 8'b000);
      if (e == 30) chk("align_en2", 8'(en[2]), 8'd1);
    end
    align = 1'b0;

    // Lock loss during RUN.
    lock = 1'b0;
    tick();
    tick();
    chk("fall_hold", 8'(ready), 8'd1);
    tick();
    chk("fall_ready", 8'(ready), 8'd0);
    chk("fall_en",    8'(en),    8'd0);
    chk("fall_loss",  loss_cnt,  8'd1);

    // Random lock segments with sporadic align pulses.
    repeat (120) begin
      lock = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 40)) begin
        align = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    align = 1'b0;

    // Repeated losses from RUN saturate the counter.
    repeat (300) begin
      lock = 1'b1;
      wait_ready(40);
      lock = 1'b0;
      repeat (3) tick();
    end
    chk("loss_sat", loss_cnt, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_en_seq.md
CLK_EN_SEQ -- requirements
Module: clk_en_seq

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, meaning the number of clock-enable channels (1..8).
REQ-002 The block SHALL have parameter DIV_W, default 8, meaning the width of each channel divisor.
REQ-003 The block SHALL have parameter DIVS, default {8'd40, 8'd10, 8'd4}, meaning the packed NUM_CH*DIV_W per-channel divisors, with channel 0 in the LSBs.
REQ-004 The block SHALL have parameter LOCK_CYCLES, default 1024, meaning the number of consecutive locked cycles required before release (>=2).
REQ-005 The block SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the lock synchroniser (>=2).
REQ-006 The block SHALL have port clk, input, 1, the single clock (PLL output domain).
REQ-007 The block SHALL have port reset_n, input, 1, a reset that is asynchronous and active-low.
REQ-008 The block SHALL have port lock, input, 1, the PLL lock indicator, asynchronous to clk.
REQ-009 The block SHALL have port align, input, 1, a synchronous pulse that restarts all channel phases.
REQ-010 The block SHALL have port ready, output, 1, which is high while the clock is stable and the downstream logic may run.
REQ-011 The block SHALL have port rst_out_n, output, 1, the active-low synchronous reset for downstream logic, equal to the registered ready.
REQ-012 The block SHALL have port en, output, NUM_CH, the one-cycle clock-enable strobes, one bit per channel.
REQ-013 The block SHALL have port loss_cnt, output, 8, a saturating count of lock losses seen while in RUN.

Function
REQ-014 The block SHALL pass lock through a SYNC_STAGES flop chain to produce lock_s; all further logic SHALL use lock_s only.
REQ-015 The block SHALL implement an FSM with three states: WAIT_LOCK, SETTLE and RUN.
REQ-016 In WAIT_LOCK, when lock_s=1 the FSM SHALL move to SETTLE and clear the settle counter.
REQ-017 In SETTLE, the settle counter SHALL increment on each edge where lock_s=1; on reaching LOCK_CYCLES-1 with lock_s=1, the FSM SHALL move to RUN.
REQ-018 In any state, lock_s=0 SHALL move the FSM to WAIT_LOCK on the next edge and clear the settle counter; a glitch during SETTLE SHALL restart the full settle count.
REQ-019 ready SHALL be registered and equal to (state==RUN).
REQ-020 With lock driven synchronously, ready SHALL rise exactly SYNC_STAGES+LOCK_CYCLES edges after lock rises, and SHALL fall exactly SYNC_STAGES+1 edges after lock falls.
REQ-021 The effective divisor SHALL be D_i = DIVS[i]; a value of 0 SHALL be treated as 1.
REQ-022 Each channel SHALL have a DIV_W-bit down-counter that is held at D_i-1 while not in RUN.
REQ-023 In RUN, each channel counter SHALL decrement each cycle and reload D_i-1 when it is 0.
REQ-024 en[i] SHALL be registered and high for exactly one cycle when its counter is 0 and the FSM is in RUN.
REQ-025 The first en[i] pulse SHALL occur D_i cycles after ready rises, with subsequent pulses every D_i cycles and no drift.
REQ-026 If D_i=1, en[i] SHALL be high on every cycle that ready is high.
REQ-027 en SHALL be all-zero whenever ready=0, including the edge on which ready falls.
REQ-028 When align=1 in RUN, all channel counters SHALL reload D_i-1 and en SHALL be 0 on the following cycle, even if a pulse would have coincided; the phase SHALL then restart as at ready rise.
REQ-029 When align=1 outside RUN, it SHALL be ignored.
REQ-030 loss_cnt SHALL increment on each RUN->WAIT_LOCK transition and saturate at 255; it SHALL not count losses during SETTLE.

Reset
REQ-031 While reset_n=0, all flops SHALL clear asynchronously: sync chain=0, state=WAIT_LOCK, settle counter=0, channel counters=D_i-1, ready=0, rst_out_n=0, en=0, loss_cnt=0.
REQ-032 Deassertion of reset_n SHALL be taken synchronously to clk; the first active edge after deassertion SHALL behave as WAIT_LOCK with an empty sync chain.
REQ-033 Asserting reset_n mid-RUN SHALL drop ready, rst_out_n and en immediately, without waiting for a clock edge.

Verification (LOCK_CYCLES=16, SYNC_STAGES=2, DIVS={4,3,1})
REQ-034 The bench SHALL cover this scenario: lock rises after edge 0 and stays high -> ready=1 and rst_out_n=1 at edge 18; en[0] high every cycle from edge 18; en[1] first high at edge 21; en[2] first high at edge 22, then every 4 cycles.
REQ-035 The bench SHALL cover this scenario: lock drops for 1 cycle at settle count 10 -> ready stays 0 and rises 16 edges after lock_s returns; loss_cnt=0.
REQ-036 The bench SHALL cover this scenario: lock falls during RUN -> ready=0 and en=0 at edge +3, and loss_cnt increments to 1.
REQ-037 The bench SHALL cover this scenario: align pulsed on the cycle where en[2] would fire -> en[2]=0 on that cycle, with the next en[2] exactly 4 cycles after align.
REQ-038 The bench SHALL cover this scenario: 300 lock-loss cycles from RUN -> loss_cnt saturates at 255.
REQ-039 The bench SHALL cover this scenario: reset_n asserted between edges in RUN -> all outputs go to their reset values before the next edge.
